// File: rtl/merge_pass_sched_pkg.sv
// Shared types for the bottom-up merge pass scheduler: job record, FSM states
// and the run length that sort_16 leaves in the source bank.
package merge_pass_sched_pkg;

  localparam int MAX_ADDR_W   = 8;
  localparam int INIT_RUN_LEN = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_PASS_END,
    S_DONE
  } sched_state_e;

  typedef struct packed {
    logic [MAX_ADDR_W:0] left_base;
    logic [MAX_ADDR_W:0] left_len;
    logic [MAX_ADDR_W:0] right_base;
    logic [MAX_ADDR_W:0] right_len;
    logic [MAX_ADDR_W:0] dst_base;
  } merge_job_t;

endpackage

// File: rtl/merge_pass_sched.sv
// Issues one merge job per run pair, doubling the run length and swapping the
// ping/pong source bank after each pass until one run covers every entry.
module merge_pass_sched
  import merge_pass_sched_pkg::*;
#(
  parameter int ADDR_W   = MAX_ADDR_W,
  parameter int INIT_RUN = INIT_RUN_LEN
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start_in,
  input  logic [ADDR_W:0] entry_count_in,
  output logic            job_valid_out,
  input  logic            job_ready_in,
  output logic [ADDR_W:0] job_left_base_out,
  output logic [ADDR_W:0] job_left_len_out,
  output logic [ADDR_W:0] job_right_base_out,
  output logic [ADDR_W:0] job_right_len_out,
  output logic [ADDR_W:0] job_dst_base_out,
  input  logic            job_done_in,
  output logic            src_sel_out,
  output logic [3:0]      pass_count_out,
  output logic            busy_out,
  output logic            done_out
);

  localparam int WW = ADDR_W + 2;
  localparam int JW = MAX_ADDR_W + 1;
  localparam logic [WW-1:0] RUN_MAX  = WW'(1) << ADDR_W;
  localparam logic [WW-1:0] RUN_INIT = WW'(INIT_RUN);

  sched_state_e  r_state, w_next;
  logic [WW-1:0] r_count, r_base, r_run_len;
  logic          r_src_sel;
  logic [3:0]    r_pass_cnt;
  logic [WW-1:0] w_left_len, w_right_len, w_base_step, w_run_dbl;
  merge_job_t    w_job;

  function automatic logic [WW-1:0] min_len(input logic [WW-1:0] a, input logic [WW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [WW-1:0] sat_sub(input logic [WW-1:0] a, input logic [WW-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

  // Run length stops at 2^ADDR_W; any legal count is covered by then.
  function automatic logic [WW-1:0] dbl_sat(input logic [WW-1:0] a);
    logic [WW:0] d;
    d = {a, 1'b0};
    return (d > {1'b0, RUN_MAX}) ? RUN_MAX : d[WW-1:0];
  endfunction

  always_comb begin
    w_left_len  = min_len(r_run_len, sat_sub(r_count, r_base));
    w_right_len = min_len(r_run_len, sat_sub(r_count, r_base + w_left_len));
    w_base_step = r_base + {r_run_len[WW-2:0], 1'b0};
    w_run_dbl   = dbl_sat(r_run_len);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE:
        if (start_in) w_next = (WW'(entry_count_in) <= RUN_INIT) ? S_DONE : S_ISSUE;
      S_ISSUE:    if (job_ready_in) w_next = S_WAIT;
      S_WAIT:     if (job_done_in)  w_next = S_NEXT;
      S_NEXT:     w_next = (w_base_step >= r_count) ? S_PASS_END : S_ISSUE;
      S_PASS_END: w_next = (w_run_dbl >= r_count) ? S_DONE : S_ISSUE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count    <= '0;
      r_base     <= '0;
      r_run_len  <= '0;
      r_src_sel  <= 1'b0;
      r_pass_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE:
          if (start_in) begin
            r_count    <= WW'(entry_count_in);
            r_base     <= '0;
            r_run_len  <= RUN_INIT;
            r_src_sel  <= 1'b0;
            r_pass_cnt <= '0;
          end
        S_NEXT:
          if (w_base_step < r_count) r_base <= w_base_step;
        S_PASS_END: begin
          r_src_sel  <= ~r_src_sel;
          r_run_len  <= w_run_dbl;
          r_pass_cnt <= r_pass_cnt + 4'd1;
          r_base     <= '0;
        end
        default: ;
      endcase
    end
  end

  // Job fields are driven only while a job is presented, zero otherwise.
  always_comb begin
    w_job         = '0;
    job_valid_out = 1'b0;
    if (r_state == S_ISSUE) begin
      job_valid_out    = 1'b1;
      w_job.left_base  = JW'(r_base);
      w_job.left_len   = JW'(w_left_len);
      w_job.right_base = JW'(r_base + w_left_len);
      w_job.right_len  = JW'(w_right_len);
      w_job.dst_base   = JW'(r_base);
    end
    job_left_base_out  = w_job.left_base[ADDR_W:0];
    job_left_len_out   = w_job.left_len[ADDR_W:0];
    job_right_base_out = w_job.right_base[ADDR_W:0];
    job_right_len_out  = w_job.right_len[ADDR_W:0];
    job_dst_base_out   = w_job.dst_base[ADDR_W:0];
    src_sel_out        = r_src_sel;
    pass_count_out     = r_pass_cnt;
    busy_out           = (r_state != S_IDLE) && (r_state != S_DONE);
    done_out           = (r_state == S_DONE);
  end

endmodule
